csr_regfile: RTL and testbench



---
 rtl/csr_regfile_pkg.sv | 77 +++++++
 rtl/csr_timer.sv | 50 +++++
 rtl/csr_regfile.sv | 278 +++++++++++++++++++++++++++
 tb/tb_csr_regfile.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the CSR register file: CSR numbers, exception
// codes, field bit positions, field structs and the masked-write helper.
package csr_regfile_pkg;

  // CSR numbers
  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_TLBIDX    = 14'h010;
  localparam logic [13:0] CSR_TLBEHI    = 14'h011;
  localparam logic [13:0] CSR_ASID      = 14'h018;
  localparam logic [13:0] CSR_SAVE0     = 14'h030;
  localparam logic [13:0] CSR_SAVE1     = 14'h031;
  localparam logic [13:0] CSR_SAVE2     = 14'h032;
  localparam logic [13:0] CSR_SAVE3     = 14'h033;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  // Exception codes that influence BADV / TLB refill handling
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Field bit positions (single bits, or LSB of a multi-bit field)
  localparam int CRMD_PLV          = 0;
  localparam int CRMD_IE           = 2;
  localparam int CRMD_DA           = 3;
  localparam int CRMD_PG           = 4;
  localparam int PRMD_PPLV         = 0;
  localparam int PRMD_PIE          = 2;
  localparam int ESTAT_IS          = 0;
  localparam int ESTAT_ECODE       = 16;
  localparam int ESTAT_ESUBCODE    = 22;
  localparam int TLBIDX_INDEX      = 0;
  localparam int TLBIDX_PS         = 24;
  localparam int TLBIDX_NE         = 31;
  localparam int TLBEHI_VPPN       = 13;
  localparam int TCFG_EN           = 0;
  localparam int TCFG_PERIODIC     = 1;
  localparam int TCFG_INITV        = 2;

  localparam logic [7:0] ASID_BITS = 8'd10;

  typedef struct packed {
    logic       pg;
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  typedef struct packed {
    logic       pie;
    logic [1:0] pplv;
  } prmd_t;

  localparam crmd_t CRMD_RESET = '{pg: 1'b0, da: 1'b1, ie: 1'b0, plv: 2'd0};

  // Bit-masked merge of a software write into the current register value
  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: owns TCFG, TVAL and the timer interrupt bit (ESTAT.IS[11]).
// Only instantiated when CSR_TIMER_EN is defined.
module csr_timer
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ticlr_we,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               timer_int
);

  logic tick;

  // The 1->0 step of an enabled count raises the interrupt; a TCFG write
  // in the same cycle reloads the counter instead of stepping it.
  always_comb tick = tcfg[TCFG_EN] && !tcfg_we && (tval == TIMER_W'(1));

  // TCFG write loads TVAL; otherwise count down, reloading only when periodic
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg <= '0;
      tval <= '0;
    end else if (tcfg_we) begin
      tcfg <= tcfg_wdata;
      tval <= {tcfg_wdata[TIMER_W-1:TCFG_INITV], 2'b00};
    end else if (tcfg[TCFG_EN]) begin
      if (tval != '0)
        tval <= tval - TIMER_W'(1);
      else if (tcfg[TCFG_PERIODIC])
        tval <= {tcfg[TIMER_W-1:TCFG_INITV], 2'b00};
    end
  end

  // Interrupt bit: set beats a simultaneous TICLR clear
  always_ff @(posedge clk) begin
    if (!resetn)
      timer_int <= 1'b0;
    else if (tick)
      timer_int <= 1'b1;
    else if (ticlr_we)
      timer_int <= 1'b0;
  end

endmodule

// File: rtl/csr_regfile.sv
// Privileged CSR file: exception/ertn context, interrupt collection, TLB
// maintenance fields and (with CSR_TIMER_EN defined) the constant timer.
// Event inputs (wb_ex, ertn_flush, tlbsrch_we, tlbrd_we, csr_we) are
// single-cycle commit strobes with no backpressure; when several fire in one
// cycle the later assignment in each block wins, giving
// wb_ex > ertn_flush > tlbrd/tlbsrch > csr_we per field.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int TLBNUM  = 16,
  parameter int TIMER_W = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [13:0]               csr_num,
  output logic [31:0]               csr_rvalue,
  input  logic                      csr_we,
  input  logic [31:0]               csr_wmask,
  input  logic [31:0]               csr_wvalue,
  input  logic                      wb_ex,
  input  logic                      ertn_flush,
  input  logic [5:0]                wb_ecode,
  input  logic [8:0]                wb_esubcode,
  input  logic [31:0]               wb_pc,
  input  logic [31:0]               wb_vaddr,
  output logic [31:0]               ex_entry,
  output logic [31:0]               ertn_entry,
  output logic                      has_int,
  input  logic [7:0]                hw_int_in,
  input  logic                      ipi_int_in,
  input  logic                      tlbsrch_we,
  input  logic                      tlbsrch_hit,
  input  logic [$clog2(TLBNUM)-1:0] tlbsrch_hit_index,
  input  logic                      tlbrd_we,
  input  logic                      tlbrd_valid,
  input  logic [18:0]               tlbrd_vppn,
  input  logic [5:0]                tlbrd_ps,
  input  logic [9:0]                tlbrd_asid,
  output logic [$clog2(TLBNUM)-1:0] csr_tlbidx_index,
  output logic [9:0]                csr_asid,
  output logic [18:0]               csr_tlbehi_vppn,
  output logic [1:0]                csr_crmd_plv
);

  localparam int IDX_W = $clog2(TLBNUM);

  crmd_t             crmd;
  prmd_t             prmd;
  logic [12:0]       ecfg_lie;
  logic [1:0]        estat_sw;
  logic [7:0]        estat_hw;
  logic              estat_ipi;
  logic [5:0]        estat_ecode;
  logic [8:0]        estat_esubcode;
  logic [31:0]       era;
  logic [31:0]       badv;
  logic [31:0]       tid;
  logic [25:0]       eentry_va;
  logic [25:0]       tlbrentry_pa;
  logic [31:0]       save_q [4];
  logic [IDX_W-1:0]  tlbidx_index;
  logic [5:0]        tlbidx_ps;
  logic              tlbidx_ne;
  logic [18:0]       tlbehi_vppn;
  logic [9:0]        asid_asid;
  logic              timer_is;
  logic [31:0]       tcfg_value;
  logic [31:0]       tval_value;
  logic [12:0]       estat_is;
  logic [31:0]       csr_wdata;
  logic [5:0]        entry_ecode;

`ifdef CSR_TIMER_EN
  logic [TIMER_W-1:0] tcfg_q;
  logic [TIMER_W-1:0] tval_q;

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (csr_we && (csr_num == CSR_TCFG)),
    .tcfg_wdata (csr_wdata[TIMER_W-1:0]),
    .ticlr_we   (csr_we && (csr_num == CSR_TICLR) && csr_wdata[0]),
    .tcfg       (tcfg_q),
    .tval       (tval_q),
    .timer_int  (timer_is)
  );

  assign tcfg_value = 32'(tcfg_q);
  assign tval_value = 32'(tval_q);
`else
  assign tcfg_value = '0;
  assign tval_value = '0;
  assign timer_is   = 1'b0;
`endif

  assign estat_is = {estat_ipi, timer_is, 1'b0, estat_hw, estat_sw};

  // Old value for a masked write is whatever the addressed CSR reads as now
  assign csr_wdata = csr_merge(csr_rvalue, csr_wmask, csr_wvalue);

  // CRMD/PRMD: software writes, then ertn restore, then exception save
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd <= CRMD_RESET;
      prmd <= '0;
    end else begin
      if (csr_we && (csr_num == CSR_CRMD)) begin
        crmd.plv <= csr_wdata[CRMD_PLV +: 2];
        crmd.ie  <= csr_wdata[CRMD_IE];
        crmd.da  <= csr_wdata[CRMD_DA];
        crmd.pg  <= csr_wdata[CRMD_PG];
      end
      if (csr_we && (csr_num == CSR_PRMD)) begin
        prmd.pplv <= csr_wdata[PRMD_PPLV +: 2];
        prmd.pie  <= csr_wdata[PRMD_PIE];
      end
      if (ertn_flush) begin
        crmd.plv <= prmd.pplv;
        crmd.ie  <= prmd.pie;
        if (estat_ecode == ECODE_TLBR) begin
          crmd.da <= 1'b0;
          crmd.pg <= 1'b1;
        end
      end
      if (wb_ex) begin
        prmd.pplv <= crmd.plv;
        prmd.pie  <= crmd.ie;
        crmd.plv  <= 2'd0;
        crmd.ie   <= 1'b0;
        if (wb_ecode == ECODE_TLBR) begin
          crmd.da <= 1'b1;
          crmd.pg <= 1'b0;
        end
      end
    end
  end

  // ESTAT: sample interrupt lines each cycle, latch cause on exception
  always_ff @(posedge clk) begin
    if (!resetn) begin
      estat_sw       <= '0;
      estat_hw       <= '0;
      estat_ipi      <= 1'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
    end else begin
      estat_hw  <= hw_int_in;
      estat_ipi <= ipi_int_in;
      if (csr_we && (csr_num == CSR_ESTAT))
        estat_sw <= csr_wdata[ESTAT_IS +: 2];
      if (wb_ex) begin
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
      end
    end
  end

  // Plain software registers plus ERA/BADV capture on exception
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ecfg_lie     <= '0;
      era          <= '0;
      badv         <= '0;
      eentry_va    <= '0;
      tlbrentry_pa <= '0;
      tid          <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      if (csr_we) begin
        case (csr_num)
          CSR_ECFG:      ecfg_lie     <= csr_wdata[12:0];
          CSR_ERA:       era          <= csr_wdata;
          CSR_BADV:      badv         <= csr_wdata;
          CSR_EENTRY:    eentry_va    <= csr_wdata[31:6];
          CSR_TLBRENTRY: tlbrentry_pa <= csr_wdata[31:6];
          CSR_TID:       tid          <= csr_wdata;
          CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                         save_q[csr_num[1:0]] <= csr_wdata;
          default: ;
        endcase
      end
      if (wb_ex) begin
        era <= wb_pc;
        case (wb_ecode)
          ECODE_ADE: if (wb_esubcode == 9'd0) badv <= wb_pc;
          ECODE_PIF: badv <= wb_pc;
          ECODE_ALE, ECODE_TLBR, ECODE_PIL, ECODE_PIS, ECODE_PPI, ECODE_PME:
                     badv <= wb_vaddr;
          default: ;
        endcase
      end
    end
  end

  // TLBIDX/TLBEHI/ASID: software, then TLB commits, then TLB refill capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tlbidx_index <= '0;
      tlbidx_ps    <= '0;
      tlbidx_ne    <= 1'b0;
      tlbehi_vppn  <= '0;
      asid_asid    <= '0;
    end else begin
      if (csr_we && (csr_num == CSR_TLBIDX)) begin
        tlbidx_index <= csr_wdata[TLBIDX_INDEX +: IDX_W];
        tlbidx_ps    <= csr_wdata[TLBIDX_PS +: 6];
        tlbidx_ne    <= csr_wdata[TLBIDX_NE];
      end
      if (csr_we && (csr_num == CSR_TLBEHI))
        tlbehi_vppn <= csr_wdata[TLBEHI_VPPN +: 19];
      if (csr_we && (csr_num == CSR_ASID))
        asid_asid <= csr_wdata[9:0];
      if (tlbsrch_we) begin
        if (tlbsrch_hit) begin
          tlbidx_index <= tlbsrch_hit_index;
          tlbidx_ne    <= 1'b0;
        end else begin
          tlbidx_ne    <= 1'b1;
        end
      end
      if (tlbrd_we) begin
        if (tlbrd_valid) begin
          tlbehi_vppn <= tlbrd_vppn;
          tlbidx_ps   <= tlbrd_ps;
          tlbidx_ne   <= 1'b0;
          asid_asid   <= tlbrd_asid;
        end else begin
          tlbehi_vppn <= '0;
          tlbidx_ps   <= '0;
          tlbidx_ne   <= 1'b1;
          asid_asid   <= '0;
        end
      end
      if (wb_ex && (wb_ecode == ECODE_TLBR))
        tlbehi_vppn <= wb_esubcode[8] ? wb_pc[31:13] : wb_vaddr[31:13];
    end
  end

  // Combinational read port; unimplemented numbers and TICLR read zero
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:      csr_rvalue = {27'd0, crmd};
      CSR_PRMD:      csr_rvalue = {29'd0, prmd};
      CSR_ECFG:      csr_rvalue = {19'd0, ecfg_lie};
      CSR_ESTAT:     csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'd0, estat_is};
      CSR_ERA:       csr_rvalue = era;
      CSR_BADV:      csr_rvalue = badv;
      CSR_EENTRY:    csr_rvalue = {eentry_va, 6'd0};
      CSR_TLBIDX:    csr_rvalue = {tlbidx_ne, 1'b0, tlbidx_ps, {(24-IDX_W){1'b0}}, tlbidx_index};
      CSR_TLBEHI:    csr_rvalue = {tlbehi_vppn, 13'd0};
      CSR_ASID:      csr_rvalue = {8'd0, ASID_BITS, 6'd0, asid_asid};
      CSR_SAVE0:     csr_rvalue = save_q[0];
      CSR_SAVE1:     csr_rvalue = save_q[1];
      CSR_SAVE2:     csr_rvalue = save_q[2];
      CSR_SAVE3:     csr_rvalue = save_q[3];
      CSR_TID:       csr_rvalue = tid;
      CSR_TCFG:      csr_rvalue = tcfg_value;
      CSR_TVAL:      csr_rvalue = tval_value;
      CSR_TLBRENTRY: csr_rvalue = {tlbrentry_pa, 6'd0};
      default:       csr_rvalue = '0;
    endcase
  end

  // Exception target follows the committing ecode while wb_ex is high
  always_comb begin
    entry_ecode = wb_ex ? wb_ecode : estat_ecode;
    ex_entry    = (entry_ecode == ECODE_TLBR) ? {tlbrentry_pa, 6'd0} : {eentry_va, 6'd0};
  end

  assign ertn_entry       = era;
  assign has_int          = (|(estat_is & ecfg_lie)) & crmd.ie;
  assign csr_tlbidx_index = tlbidx_index;
  assign csr_asid         = asid_asid;
  assign csr_tlbehi_vppn  = tlbehi_vppn;
  assign csr_crmd_plv     = crmd.plv;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset values, exception/ertn flow, TLB
// refill, interrupts, timer (when CSR_TIMER_EN is defined), TLB commits and
// same-cycle priority.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        tlbsrch_we;
  logic        tlbsrch_hit;
  logic [3:0]  tlbsrch_hit_index;
  logic        tlbrd_we;
  logic        tlbrd_valid;
  logic [18:0] tlbrd_vppn;
  logic [5:0]  tlbrd_ps;
  logic [9:0]  tlbrd_asid;
  logic [3:0]  csr_tlbidx_index;
  logic [9:0]  csr_asid;
  logic [18:0] csr_tlbehi_vppn;
  logic [1:0]  csr_crmd_plv;

  int total = 0;
  int bad   = 0;

  csr_regfile #(.TLBNUM(16), .TIMER_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .csr_num           (csr_num),
    .csr_rvalue        (csr_rvalue),
    .csr_we            (csr_we),
    .csr_wmask         (csr_wmask),
    .csr_wvalue        (csr_wvalue),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .wb_vaddr          (wb_vaddr),
    .ex_entry          (ex_entry),
    .ertn_entry        (ertn_entry),
    .has_int           (has_int),
    .hw_int_in         (hw_int_in),
    .ipi_int_in        (ipi_int_in),
    .tlbsrch_we        (tlbsrch_we),
    .tlbsrch_hit       (tlbsrch_hit),
    .tlbsrch_hit_index (tlbsrch_hit_index),
    .tlbrd_we          (tlbrd_we),
    .tlbrd_valid       (tlbrd_valid),
    .tlbrd_vppn        (tlbrd_vppn),
    .tlbrd_ps          (tlbrd_ps),
    .tlbrd_asid        (tlbrd_asid),
    .csr_tlbidx_index  (csr_tlbidx_index),
    .csr_asid          (csr_asid),
    .csr_tlbehi_vppn   (csr_tlbehi_vppn),
    .csr_crmd_plv      (csr_crmd_plv)
  );

  // Clock: 20 time-unit period; inputs change 1 unit after each rising edge
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [13:0] num, output logic [31:0] val);
    csr_num = num;
    #1;
    val = csr_rvalue;
  endtask

  task automatic write_csr(input logic [13:0] num, input logic [31:0] val,
                           input logic [31:0] mask);
    csr_num    = num;
    csr_wvalue = val;
    csr_wmask  = mask;
    csr_we     = 1'b1;
    step();
    csr_we     = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    read_csr(14'h000, v);
    total++; if (v !== 32'h00000008) begin bad++; $display("FAIL reset_crmd got=%h exp=%h", v, 32'h8); end
    read_csr(14'h005, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_estat got=%h exp=0", v); end
    read_csr(14'h042, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_tval got=%h exp=0", v); end
    read_csr(14'h010, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_tlbidx got=%h exp=0", v); end
    total++;
    if ({ex_entry, ertn_entry, has_int, csr_tlbidx_index, csr_asid, csr_tlbehi_vppn, csr_crmd_plv} !== '0) begin
      bad++;
      $display("FAIL reset_outputs ex=%h ertn=%h int=%b idx=%h asid=%h vppn=%h plv=%h exp=all zero",
               ex_entry, ertn_entry, has_int, csr_tlbidx_index, csr_asid, csr_tlbehi_vppn, csr_crmd_plv);
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    write_csr(14'h00C, 32'h1C008000, 32'hFFFFFFFF);
    write_csr(14'h000, 32'h00000007, 32'h00000007);
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'd0;
    wb_pc = 32'h1C000100; wb_vaddr = 32'h0;
    #1;
    total++; if (ex_entry !== 32'h1C008000) begin bad++; $display("FAIL sys_ex_entry got=%h exp=%h", ex_entry, 32'h1C008000); end
    step();
    wb_ex = 1'b0;
    read_csr(14'h006, v);
    total++; if (v !== 32'h1C000100) begin bad++; $display("FAIL sys_era got=%h exp=%h", v, 32'h1C000100); end
    read_csr(14'h001, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL sys_prmd got=%h exp=7", v); end
    read_csr(14'h000, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL sys_crmd got=%h exp=8", v); end
    read_csr(14'h005, v);
    total++; if (v !== 32'h000B0000) begin bad++; $display("FAIL sys_estat got=%h exp=%h", v, 32'h000B0000); end
    read_csr(14'h007, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL sys_badv_untouched got=%h exp=0", v); end
    ertn_flush = 1'b1;
    #1;
    total++; if (ertn_entry !== 32'h1C000100) begin bad++; $display("FAIL ertn_entry got=%h exp=%h", ertn_entry, 32'h1C000100); end
    step();
    ertn_flush = 1'b0;
    read_csr(14'h000, v);
    total++; if (v !== 32'hF) begin bad++; $display("FAIL ertn_crmd got=%h exp=f", v); end
    total++; if (csr_crmd_plv !== 2'd3) begin bad++; $display("FAIL ertn_plv_port got=%h exp=3", csr_crmd_plv); end
  endtask

  task automatic test_tlbr();
    logic [31:0] v;
    write_csr(14'h088, 32'h1C00F000, 32'hFFFFFFFF);
    wb_ex = 1'b1; wb_ecode = 6'h3F; wb_esubcode = 9'd0;
    wb_pc = 32'h1C000300; wb_vaddr = 32'h00402ABC;
    #1;
    total++; if (ex_entry !== 32'h1C00F000) begin bad++; $display("FAIL tlbr_ex_entry got=%h exp=%h", ex_entry, 32'h1C00F000); end
    step();
    wb_ex = 1'b0;
    read_csr(14'h007, v);
    total++; if (v !== 32'h00402ABC) begin bad++; $display("FAIL tlbr_badv got=%h exp=%h", v, 32'h00402ABC); end
    total++; if (csr_tlbehi_vppn !== 19'h00201) begin bad++; $display("FAIL tlbr_vppn got=%h exp=00201", csr_tlbehi_vppn); end
    read_csr(14'h000, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL tlbr_crmd got=%h exp=8", v); end
    total++; if (ex_entry !== 32'h1C00F000) begin bad++; $display("FAIL tlbr_ex_entry_held got=%h exp=%h", ex_entry, 32'h1C00F000); end
    ertn_flush = 1'b1;
    step();
    ertn_flush = 1'b0;
    read_csr(14'h000, v);
    total++; if (v !== 32'h17) begin bad++; $display("FAIL tlbr_ertn_crmd got=%h exp=17", v); end
  endtask

  task automatic test_interrupts();
    logic [31:0] v;
    hw_int_in = 8'h01;
    write_csr(14'h004, 32'h00000004, 32'hFFFFFFFF);
    total++; if (has_int !== 1'b1) begin bad++; $display("FAIL int_hw got=%b exp=1", has_int); end
    read_csr(14'h005, v);
    total++; if (v !== 32'h003F0004) begin bad++; $display("FAIL int_hw_estat got=%h exp=%h", v, 32'h003F0004); end
    write_csr(14'h000, 32'h0, 32'h00000004);
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL int_ie_off got=%b exp=0", has_int); end
    write_csr(14'h000, 32'h4, 32'h00000004);
    hw_int_in = 8'h00;
    step();
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL int_hw_drop got=%b exp=0", has_int); end
    write_csr(14'h004, 32'h00001002, 32'hFFFFFFFF);
    write_csr(14'h005, 32'h00000002, 32'h00000003);
    total++; if (has_int !== 1'b1) begin bad++; $display("FAIL int_sw got=%b exp=1", has_int); end
    read_csr(14'h005, v);
    total++; if (v !== 32'h003F0002) begin bad++; $display("FAIL int_sw_estat got=%h exp=%h", v, 32'h003F0002); end
    write_csr(14'h005, 32'h00000000, 32'hFFFFFFFF);
    read_csr(14'h005, v);
    total++; if (v !== 32'h003F0000) begin bad++; $display("FAIL estat_readonly got=%h exp=%h", v, 32'h003F0000); end
    ipi_int_in = 1'b1;
    step();
    total++; if (has_int !== 1'b1) begin bad++; $display("FAIL int_ipi got=%b exp=1", has_int); end
    read_csr(14'h005, v);
    total++; if (v !== 32'h003F1000) begin bad++; $display("FAIL int_ipi_estat got=%h exp=%h", v, 32'h003F1000); end
    ipi_int_in = 1'b0;
    write_csr(14'h004, 32'h0, 32'hFFFFFFFF);
  endtask

`ifdef CSR_TIMER_EN
  task automatic test_timer();
    logic [31:0] v;
    int n;
    write_csr(14'h004, 32'h00000800, 32'hFFFFFFFF);
    // periodic, InitVal=3 -> count 12
    write_csr(14'h041, 32'h0000000F, 32'hFFFFFFFF);
    read_csr(14'h042, v);
    total++; if (v !== 32'd12) begin bad++; $display("FAIL timer_load got=%0d exp=12", v); end
    n = 0;
    read_csr(14'h005, v);
    while (v[11] == 1'b0 && n < 40) begin
      step(); n++;
      read_csr(14'h005, v);
    end
    total++; if (n !== 12) begin bad++; $display("FAIL timer_periodic_delay got=%0d exp=12", n); end
    total++; if (has_int !== 1'b1) begin bad++; $display("FAIL timer_has_int got=%b exp=1", has_int); end
    read_csr(14'h042, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL timer_zero got=%0d exp=0", v); end
    step();
    read_csr(14'h042, v);
    total++; if (v !== 32'd12) begin bad++; $display("FAIL timer_reload got=%0d exp=12", v); end
    write_csr(14'h044, 32'h1, 32'hFFFFFFFF);
    read_csr(14'h005, v);
    total++; if (v[11] !== 1'b0) begin bad++; $display("FAIL ticlr_clear got=%b exp=0", v[11]); end
    total++; if (has_int !== 1'b0) begin bad++; $display("FAIL ticlr_has_int got=%b exp=0", has_int); end
    read_csr(14'h044, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL ticlr_read got=%h exp=0", v); end
    // one-shot
    write_csr(14'h041, 32'h0000000D, 32'hFFFFFFFF);
    n = 0;
    read_csr(14'h005, v);
    while (v[11] == 1'b0 && n < 40) begin
      step(); n++;
      read_csr(14'h005, v);
    end
    total++; if (n !== 12) begin bad++; $display("FAIL timer_oneshot_delay got=%0d exp=12", n); end
    write_csr(14'h044, 32'h1, 32'hFFFFFFFF);
    repeat (30) step();
    read_csr(14'h005, v);
    total++; if (v[11] !== 1'b0) begin bad++; $display("FAIL timer_oneshot_refire got=%b exp=0", v[11]); end
    read_csr(14'h042, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL timer_oneshot_hold got=%0d exp=0", v); end
    write_csr(14'h004, 32'h0, 32'hFFFFFFFF);
  endtask
`else
  task automatic test_timer();
    logic [31:0] v;
    write_csr(14'h041, 32'h0000000F, 32'hFFFFFFFF);
    read_csr(14'h041, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL notimer_tcfg got=%h exp=0", v); end
    read_csr(14'h042, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL notimer_tval got=%h exp=0", v); end
    repeat (20) step();
    read_csr(14'h005, v);
    total++; if (v[11] !== 1'b0) begin bad++; $display("FAIL notimer_is11 got=%b exp=0", v[11]); end
  endtask
`endif

  task automatic test_tlbsrch();
    logic [31:0] v;
    tlbsrch_we = 1'b1; tlbsrch_hit = 1'b0; tlbsrch_hit_index = 4'd7;
    step();
    read_csr(14'h010, v);
    total++; if (v !== 32'h80000000) begin bad++; $display("FAIL srch_miss got=%h exp=%h", v, 32'h80000000); end
    tlbsrch_hit = 1'b1; tlbsrch_hit_index = 4'd5;
    step();
    read_csr(14'h010, v);
    total++; if (v !== 32'h00000005) begin bad++; $display("FAIL srch_hit got=%h exp=5", v); end
    tlbsrch_hit = 1'b0; tlbsrch_hit_index = 4'd9;
    step();
    tlbsrch_we = 1'b0;
    read_csr(14'h010, v);
    total++; if (v !== 32'h80000005) begin bad++; $display("FAIL srch_miss_keep got=%h exp=%h", v, 32'h80000005); end
    total++; if (csr_tlbidx_index !== 4'd5) begin bad++; $display("FAIL srch_index_port got=%h exp=5", csr_tlbidx_index); end
  endtask

  task automatic test_tlbrd();
    logic [31:0] v;
    tlbrd_we = 1'b1; tlbrd_valid = 1'b1;
    tlbrd_vppn = 19'h12345; tlbrd_ps = 6'd12; tlbrd_asid = 10'h03A;
    step();
    read_csr(14'h010, v);
    total++; if (v !== 32'h0C000005) begin bad++; $display("FAIL rd_valid_tlbidx got=%h exp=%h", v, 32'h0C000005); end
    total++; if (csr_tlbehi_vppn !== 19'h12345) begin bad++; $display("FAIL rd_valid_vppn got=%h exp=12345", csr_tlbehi_vppn); end
    total++; if (csr_asid !== 10'h03A) begin bad++; $display("FAIL rd_valid_asid got=%h exp=03a", csr_asid); end
    read_csr(14'h011, v);
    total++; if (v !== 32'h2468A000) begin bad++; $display("FAIL rd_valid_tlbehi got=%h exp=%h", v, 32'h2468A000); end
    read_csr(14'h018, v);
    total++; if (v !== 32'h000A003A) begin bad++; $display("FAIL rd_valid_asidreg got=%h exp=%h", v, 32'h000A003A); end
    tlbrd_valid = 1'b0;
    step();
    tlbrd_we = 1'b0;
    read_csr(14'h010, v);
    total++; if (v !== 32'h80000005) begin bad++; $display("FAIL rd_invalid_tlbidx got=%h exp=%h", v, 32'h80000005); end
    total++; if ({csr_tlbehi_vppn, csr_asid} !== '0) begin bad++; $display("FAIL rd_invalid_clear vppn=%h asid=%h exp=0", csr_tlbehi_vppn, csr_asid); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    csr_num = 14'h006; csr_wvalue = 32'hDEADBEEF; csr_wmask = 32'hFFFFFFFF; csr_we = 1'b1;
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'd0; wb_pc = 32'h1C000200; wb_vaddr = 32'h0;
    step();
    csr_we = 1'b0; wb_ex = 1'b0;
    read_csr(14'h006, v);
    total++; if (v !== 32'h1C000200) begin bad++; $display("FAIL prio_era got=%h exp=%h", v, 32'h1C000200); end
    read_csr(14'h000, v);
    total++; if (v !== 32'h10) begin bad++; $display("FAIL prio_crmd got=%h exp=10", v); end
  endtask

  task automatic test_misc_regs();
    logic [31:0] v;
    write_csr(14'h032, 32'h12345678, 32'h0000FFFF);
    read_csr(14'h032, v);
    total++; if (v !== 32'h00005678) begin bad++; $display("FAIL save2_mask got=%h exp=%h", v, 32'h00005678); end
    write_csr(14'h032, 32'hABCD0000, 32'hFFFF0000);
    read_csr(14'h032, v);
    total++; if (v !== 32'hABCD5678) begin bad++; $display("FAIL save2_merge got=%h exp=%h", v, 32'hABCD5678); end
    write_csr(14'h020, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_csr(14'h020, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%h exp=0", v); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] v;
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C000400;
    resetn = 1'b0;
    step();
    wb_ex = 1'b0;
    resetn = 1'b1;
    read_csr(14'h000, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL midreset_crmd got=%h exp=8", v); end
    read_csr(14'h006, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midreset_era got=%h exp=0", v); end
    read_csr(14'h032, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL midreset_save2 got=%h exp=0", v); end
    total++; if ({ex_entry, csr_tlbidx_index} !== '0) begin bad++; $display("FAIL midreset_outputs ex=%h idx=%h exp=0", ex_entry, csr_tlbidx_index); end
  endtask

  initial begin
    resetn = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; ertn_flush = 1'b0; wb_ecode = '0; wb_esubcode = '0;
    wb_pc = '0; wb_vaddr = '0; hw_int_in = '0; ipi_int_in = 1'b0;
    tlbsrch_we = 1'b0; tlbsrch_hit = 1'b0; tlbsrch_hit_index = '0;
    tlbrd_we = 1'b0; tlbrd_valid = 1'b0; tlbrd_vppn = '0; tlbrd_ps = '0; tlbrd_asid = '0;
    test_reset();
    test_exception();
    test_tlbr();
    test_interrupts();
    test_timer();
    test_tlbsrch();
    test_tlbrd();
    test_priority();
    test_misc_regs();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
